// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache to backing-memory arbiter.
// Build option ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default: D-cache priority).
package cache_arbiter_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LINE_W = 128;

    typedef logic [ADDR_W-1:0] lc3b_wb_adr;
    typedef logic [LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RECOVER
    } lc3b_arb_state;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } lc3b_arb_port;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundles the I-cache, D-cache and pmem-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface cache_arbiter_if;
    import cache_arbiter_pkg::*;

    logic       i_read;
    lc3b_wb_adr i_address;
    lc3b_line   i_rdata;
    logic       i_resp;

    logic       d_read;
    logic       d_write;
    lc3b_wb_adr d_address;
    lc3b_line   d_wdata;
    lc3b_line   d_rdata;
    logic       d_resp;

    logic       pmem_read;
    logic       pmem_write;
    lc3b_wb_adr pmem_address;
    lc3b_line   pmem_wdata;
    lc3b_line   pmem_rdata;
    logic       pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/cache_arbiter_ctrl.sv
// Grant FSM for the cache arbiter: tracks the single outstanding transaction and last grant.
// ARB_ROUND_ROBIN_EN alternates ties; otherwise the D-cache wins every tie.
module cache_arbiter_ctrl
    import cache_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          d_req,
    input  logic          pmem_resp,
    output lc3b_arb_state state,
    output logic          grant_i,
    output logic          grant_d
);

    lc3b_arb_state state_q, state_d;
    lc3b_arb_port  last_q, last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GRANT_D;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (last_q == GRANT_D) grant_i = 1'b1;
                    else                   grant_d = 1'b1;
`else
                    grant_d = 1'b1;
`endif
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i) begin
                    state_d = SERVE_I;
                    last_d  = GRANT_I;
                end else if (grant_d) begin
                    state_d = SERVE_D;
                    last_d  = GRANT_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_d = RECOVER;
            end
            // One dead cycle so the requester can drop its level request.
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-wide backing memory between the I-cache and D-cache miss ports.
// Tie-break policy selected by ARB_ROUND_ROBIN_EN (see cache_arbiter_ctrl).
module cache_arbiter
    import cache_arbiter_pkg::*;
(
    input logic            clk,
    input logic            rst,
    cache_arbiter_if.slave bus
);

    lc3b_arb_state state;
    logic          grant_i;
    logic          grant_d;

    lc3b_wb_adr addr_q;
    lc3b_line   wdata_q;
    logic       d_write_q;

    cache_arbiter_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_req     (bus.i_read),
        .d_req     (bus.d_read | bus.d_write),
        .pmem_resp (bus.pmem_resp),
        .state     (state),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    // Writeback wins over fill when both are raised: d_write is latched as the transaction kind.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            d_write_q <= 1'b0;
        end else if (grant_i) begin
            addr_q <= bus.i_address;
        end else if (grant_d) begin
            addr_q    <= bus.d_address;
            d_write_q <= bus.d_write;
            if (bus.d_write) wdata_q <= bus.d_wdata;
        end
    end

    assign bus.pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !d_write_q);
    assign bus.pmem_write   = (state == SERVE_D) && d_write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    assign bus.i_resp  = (state == SERVE_I) && bus.pmem_resp;
    assign bus.d_resp  = (state == SERVE_D) && bus.pmem_resp;
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a transaction scoreboard; covers both tie-break builds.
module tb_cache_arbiter;

    typedef struct {
        bit          to_i;
        bit          wr;
        logic [11:0]  addr;
        logic [127:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    txn_t sb[$];

    cache_arbiter_if bus ();

    cache_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit to_i, input bit wr, input logic [11:0] a,
                        input logic [127:0] w);
        txn_t t;
        t.to_i = to_i;
        t.wr = wr;
        t.addr = a;
        t.wdata = w;
        sb.push_back(t);
    endtask

    // Wait for a strobe, compare against the scoreboard head, then answer after 'delay' cycles.
    task automatic serve(input int exp_wait, input int delay, input logic [127:0] rd,
                         input bit scramble);
        int   w;
        txn_t t;
        w = 0;
        while (!(bus.pmem_read || bus.pmem_write) && w < 12) begin
            tick();
            w++;
        end
        if (!(bus.pmem_read || bus.pmem_write)) begin
            check("strobe_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
            return;
        end
        t = sb.pop_front();
        if (exp_wait >= 0) check("latency", w, exp_wait);
        check("pmem_read", bus.pmem_read, !t.wr);
        check("pmem_write", bus.pmem_write, t.wr);
        check("pmem_address", bus.pmem_address, t.addr);
        if (t.wr) check("pmem_wdata", bus.pmem_wdata, t.wdata);
        check("early_resp", {bus.i_resp, bus.d_resp}, 0);
        for (int k = 0; k < delay; k++) begin
            if (scramble) begin
                bus.d_wdata = ~bus.d_wdata;
                bus.d_address = bus.d_address + 12'd1;
                bus.i_address = bus.i_address + 12'd1;
            end
            tick();
        end
        check("hold_address", bus.pmem_address, t.addr);
        if (t.wr) check("hold_wdata", bus.pmem_wdata, t.wdata);
        bus.pmem_rdata = rd;
        bus.pmem_resp = 1'b1;
        #1;
        check("i_resp", bus.i_resp, t.to_i);
        check("d_resp", bus.d_resp, !t.to_i);
        if (t.to_i) check("i_rdata", bus.i_rdata, rd);
        else        check("d_rdata", bus.d_rdata, rd);
        tick();
        bus.pmem_resp = 1'b0;
        #1;
        check("recover_strobe", {bus.pmem_read, bus.pmem_write}, 0);
        check("recover_resp", {bus.i_resp, bus.d_resp}, 0);
    endtask

    initial begin
        int w;
        bus.i_read = 1'b0;
        bus.i_address = '0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.d_address = '0;
        bus.d_wdata = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_strobe", {bus.pmem_read, bus.pmem_write}, 0);
        check("rst_resp", {bus.i_resp, bus.d_resp}, 0);
        check("rst_address", bus.pmem_address, 0);
        check("rst_wdata", bus.pmem_wdata, 0);
        tick();

        // 1: I-cache fill
        bus.i_address = 12'h0A0;
        bus.i_read = 1'b1;
        push(1'b1, 1'b0, 12'h0A0, '0);
        #1;
        check("t1_no_strobe_yet", bus.pmem_read, 0);
        serve(1, 3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0);
        bus.i_read = 1'b0;
        tick();

        // 2: D-cache writeback with inputs changing mid-transaction
        bus.d_address = 12'h123;
        bus.d_wdata = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
        bus.d_write = 1'b1;
        push(1'b0, 1'b1, 12'h123, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0);
        serve(1, 3, 128'h5555, 1'b1);
        bus.d_write = 1'b0;
        tick();

        // 3: simultaneous fills
        bus.i_address = 12'h200;
        bus.d_address = 12'h300;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b1, 1'b0, 12'h200, '0);
        push(1'b0, 1'b0, 12'h300, '0);
        serve(1, 1, 128'hA1, 1'b0);
        bus.i_read = 1'b0;
        serve(2, 2, 128'hA2, 1'b0);
        bus.d_read = 1'b0;
`else
        push(1'b0, 1'b0, 12'h300, '0);
        push(1'b1, 1'b0, 12'h200, '0);
        serve(1, 1, 128'hA1, 1'b0);
        bus.d_read = 1'b0;
        serve(2, 2, 128'hA2, 1'b0);
        bus.i_read = 1'b0;
`endif
        tick();

        // 4: both held across several transactions; last grant was D
        bus.i_address = 12'h044;
        bus.d_address = 12'h055;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b1, 1'b0, 12'h044, '0);
        push(1'b0, 1'b0, 12'h055, '0);
        push(1'b1, 1'b0, 12'h044, '0);
        serve(1, 0, 128'hB1, 1'b0);
        serve(2, 1, 128'hB2, 1'b0);
        serve(2, 0, 128'hB3, 1'b0);
`else
        push(1'b0, 1'b0, 12'h055, '0);
        push(1'b0, 1'b0, 12'h055, '0);
        push(1'b0, 1'b0, 12'h055, '0);
        push(1'b1, 1'b0, 12'h044, '0);
        serve(1, 0, 128'hB1, 1'b0);
        serve(2, 1, 128'hB2, 1'b0);
        serve(2, 0, 128'hB3, 1'b0);
        bus.d_read = 1'b0;
        serve(2, 0, 128'hB4, 1'b0);
`endif
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        tick();

        // 5: reset while a writeback waits on pmem
        bus.d_address = 12'h777;
        bus.d_wdata = 128'hFACE;
        bus.d_write = 1'b1;
        w = 0;
        while (!bus.pmem_write && w < 12) begin
            tick();
            w++;
        end
        check("t5_strobe", bus.pmem_write, 1);
        tick();
        tick();
        rst = 1'b1;
        bus.d_write = 1'b0;
        #1;
        check("t5_no_resp", bus.d_resp, 0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_strobe_drop", {bus.pmem_read, bus.pmem_write}, 0);
        check("t5_address_clr", bus.pmem_address, 0);
        check("t5_wdata_clr", bus.pmem_wdata, 0);
        tick();
        check("t5_stay_idle", {bus.pmem_read, bus.pmem_write, bus.d_resp}, 0);

        // 6: writeback precedes fill, then spurious pmem_resp
        bus.d_address = 12'h3C0;
        bus.d_wdata = 128'h0F0F_0F0F;
        bus.d_read = 1'b1;
        bus.d_write = 1'b1;
        push(1'b0, 1'b1, 12'h3C0, 128'h0F0F_0F0F);
        push(1'b0, 1'b0, 12'h3C0, '0);
        serve(1, 2, 128'hC1, 1'b0);
        bus.d_write = 1'b0;
        serve(2, 1, 128'hC2, 1'b0);
        bus.d_read = 1'b0;
        bus.pmem_resp = 1'b1;
        #1;
        check("t6_spur_recover", {bus.i_resp, bus.d_resp}, 0);
        tick();
        check("t6_spur_idle", {bus.i_resp, bus.d_resp}, 0);
        bus.pmem_resp = 1'b0;
        tick();
        check("t6_idle_strobe", {bus.pmem_read, bus.pmem_write}, 0);

        check("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
